// File: rtl/ifetch_tl_arbiter_if.sv
// TL-UH bundle for the instruction-side arbiter: two requester links
// (packed [1:0], index = requester number) plus the single shared master link.
// The arbiter attaches through the master modport; the requesters and the
// downstream fabric attach through the slave modport.
interface ifetch_tl_arbiter_if;
    // Requester A channels
    logic [1:0][2:0]  req_a_opcode;
    logic [1:0][2:0]  req_a_param;
    logic [1:0][3:0]  req_a_size;
    logic [1:0][31:0] req_a_address;
    logic [1:0][3:0]  req_a_mask;
    logic [1:0][31:0] req_a_data;
    logic [1:0]       req_a_corrupt;
    logic [1:0]       req_a_valid;
    logic [1:0]       req_a_ready;
    // Requester D channels (payload shared by both requesters)
    logic [1:0]       req_d_valid;
    logic [1:0]       req_d_ready;
    logic [2:0]       req_d_opcode;
    logic [1:0]       req_d_param;
    logic [3:0]       req_d_size;
    logic             req_d_denied;
    logic [31:0]      req_d_data;
    logic             req_d_corrupt;
    // Master A channel
    logic [2:0]       m_a_opcode;
    logic [2:0]       m_a_param;
    logic [3:0]       m_a_size;
    logic [31:0]      m_a_address;
    logic [3:0]       m_a_mask;
    logic [31:0]      m_a_data;
    logic             m_a_corrupt;
    logic             m_a_valid;
    logic             m_a_ready;
    // Master D channel
    logic [2:0]       m_d_opcode;
    logic [1:0]       m_d_param;
    logic [3:0]       m_d_size;
    logic             m_d_denied;
    logic [31:0]      m_d_data;
    logic             m_d_corrupt;
    logic             m_d_valid;
    logic             m_d_ready;

    modport master (
        input  req_a_opcode, req_a_param, req_a_size, req_a_address,
               req_a_mask, req_a_data, req_a_corrupt, req_a_valid,
        output req_a_ready,
        output req_d_valid,
        input  req_d_ready,
        output req_d_opcode, req_d_param, req_d_size, req_d_denied,
               req_d_data, req_d_corrupt,
        output m_a_opcode, m_a_param, m_a_size, m_a_address, m_a_mask,
               m_a_data, m_a_corrupt, m_a_valid,
        input  m_a_ready,
        input  m_d_opcode, m_d_param, m_d_size, m_d_denied, m_d_data,
               m_d_corrupt, m_d_valid,
        output m_d_ready
    );

    modport slave (
        output req_a_opcode, req_a_param, req_a_size, req_a_address,
               req_a_mask, req_a_data, req_a_corrupt, req_a_valid,
        input  req_a_ready,
        input  req_d_valid,
        output req_d_ready,
        input  req_d_opcode, req_d_param, req_d_size, req_d_denied,
               req_d_data, req_d_corrupt,
        input  m_a_opcode, m_a_param, m_a_size, m_a_address, m_a_mask,
               m_a_data, m_a_corrupt, m_a_valid,
        output m_a_ready,
        output m_d_opcode, m_d_param, m_d_size, m_d_denied, m_d_data,
               m_d_corrupt, m_d_valid,
        input  m_d_ready
    );
endinterface

// File: rtl/ifetch_tl_arbiter.sv
// Two-requester arbiter for the frontend's TL-UH instruction master port.
// One transaction in flight at a time: arbitrate A, forward it to the master,
// then steer every D beat to the owner until the response is complete.
// Requester 0 = icache refill/flush engine, requester 1 = next-line prefetcher.
module ifetch_tl_arbiter #(
    parameter int MAX_SIZE   = 6,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                 core_clock_i,
    input  logic                 core_reset_ni,
    ifetch_tl_arbiter_if.master  tl,
    output logic [1:0]           grant_o,
    output logic                 busy_o
);

    localparam logic [2:0] OP_GET     = 3'd4;
    localparam logic [3:0] MAX_SIZE_L = 4'(MAX_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t     state_r;
    logic [1:0] grant_r;
    logic       busy_r;
    logic       last_owner_r;
    logic [4:0] beats_left_r;

    logic       gidx_s;
    logic       win_s;
    logic       a_fire_s;
    logic       d_fire_s;

    // Number of 32-bit D beats a request produces. Only a Get of more than a
    // word is a burst; sizes beyond MAX_SIZE are illegal and collapse to one
    // beat so the counter can never wrap.
    function automatic logic [4:0] beat_count(input logic [2:0] op, input logic [3:0] sz);
        logic [4:0] n;
        if ((op == OP_GET) && (sz > 4'd2) && (sz <= MAX_SIZE_L)) begin
            n = 5'd1 << (sz - 4'd2);
        end else begin
            n = 5'd1;
        end
        return n;
    endfunction

    assign gidx_s   = grant_r[1];
    assign a_fire_s = (state_r == ST_ADDR) && tl.req_a_valid[gidx_s] && tl.m_a_ready;
    assign d_fire_s = (state_r == ST_RESP) && tl.m_d_valid && tl.req_d_ready[gidx_s];

    // A payload always follows the granted requester; only valid is gated.
    assign tl.m_a_opcode  = tl.req_a_opcode[gidx_s];
    assign tl.m_a_param   = tl.req_a_param[gidx_s];
    assign tl.m_a_size    = tl.req_a_size[gidx_s];
    assign tl.m_a_address = tl.req_a_address[gidx_s];
    assign tl.m_a_mask    = tl.req_a_mask[gidx_s];
    assign tl.m_a_data    = tl.req_a_data[gidx_s];
    assign tl.m_a_corrupt = tl.req_a_corrupt[gidx_s];

    // D payload is broadcast; req_d_valid decides who actually sees a beat.
    assign tl.req_d_opcode  = tl.m_d_opcode;
    assign tl.req_d_param   = tl.m_d_param;
    assign tl.req_d_size    = tl.m_d_size;
    assign tl.req_d_denied  = tl.m_d_denied;
    assign tl.req_d_data    = tl.m_d_data;
    assign tl.req_d_corrupt = tl.m_d_corrupt;

    assign grant_o = grant_r;
    assign busy_o  = busy_r;

    // Winner selection: fixed priority to r0, or round-robin away from the last owner.
    always_comb begin
        win_s = 1'b0;
        if (FIXED_PRIO) begin
            win_s = tl.req_a_valid[0] ? 1'b0 : 1'b1;
        end else if (&tl.req_a_valid) begin
            win_s = ~last_owner_r;
        end else begin
            win_s = tl.req_a_valid[1];
        end
    end

    // Handshake steering: A only in ADDR, D only in RESP, always to the owner.
    always_comb begin
        tl.m_a_valid   = 1'b0;
        tl.req_a_ready = 2'b00;
        tl.m_d_ready   = 1'b0;
        tl.req_d_valid = 2'b00;
        case (state_r)
            ST_ADDR: begin
                tl.m_a_valid           = tl.req_a_valid[gidx_s];
                tl.req_a_ready[gidx_s] = tl.m_a_ready;
            end
            ST_RESP: begin
                tl.m_d_ready           = tl.req_d_ready[gidx_s];
                tl.req_d_valid[gidx_s] = tl.m_d_valid;
            end
            default: begin
                tl.m_a_valid = 1'b0;
            end
        endcase
    end

    // Transaction FSM with registered grant/busy, beat counter and RR pointer.
    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            state_r      <= ST_IDLE;
            grant_r      <= 2'b00;
            busy_r       <= 1'b0;
            last_owner_r <= 1'b1;
            beats_left_r <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|tl.req_a_valid) begin
                        grant_r <= win_s ? 2'b10 : 2'b01;
                        busy_r  <= 1'b1;
                        state_r <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (a_fire_s) begin
                        beats_left_r <= beat_count(tl.req_a_opcode[gidx_s], tl.req_a_size[gidx_s]);
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (d_fire_s) begin
                        if (beats_left_r == 5'd1) begin
                            state_r      <= ST_IDLE;
                            grant_r      <= 2'b00;
                            busy_r       <= 1'b0;
                            last_owner_r <= gidx_s;
                            beats_left_r <= 5'd0;
                        end else begin
                            beats_left_r <= beats_left_r - 5'd1;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    grant_r      <= 2'b00;
                    busy_r       <= 1'b0;
                    beats_left_r <= 5'd0;
                end
            endcase
        end
    end

endmodule
